// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, the saturation digit and the counter width helper.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'h9;

  // Counter must hold the value BIN_W itself, hence +1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries cleanly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Pure combinational add-3 when d >= 5; no carry leaves the digit.
  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-add-3).
// Results that do not fit in DIGITS digits set overflow and saturate to 9s.
// Optional build macro BIN2BCD_SIGNED_EN: treat bin as two's complement,
// convert the magnitude and report the sign on bcd_neg.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_neg,
  output logic                  overflow
);

  localparam int CW = cnt_width(BIN_W);
  localparam int BW = 4 * DIGITS;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [BIN_W-1:0]   bin_work;
  logic [BW-1:0]      bcd_work;
  logic [BW-1:0]      bcd_adj;
  logic [BW-1:0]      bcd_nxt;
  logic               ovf_acc;
  logic               ovf_nxt;
  logic               neg_work;
  logic [BIN_W-1:0]   mag;
  logic               neg_in;

`ifdef BIN2BCD_SIGNED_EN
  // Magnitude kept at BIN_W bits so the most negative value maps to 2^(BIN_W-1).
  assign neg_in = bin[BIN_W-1];
  assign mag    = neg_in ? (BIN_W'(0) - bin) : bin;
`else
  assign neg_in = 1'b0;
  assign mag    = bin;
`endif

  // Per-digit add-3 correction ahead of the shift.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    bcd_digit_adj u_adj (
      .d (bcd_work[4*k +: 4]),
      .q (bcd_adj[4*k +: 4])
    );
  end

  // Corrected digits shifted left with the next binary bit entering at the bottom;
  // the bit falling off the top digit means the value no longer fits.
  assign bcd_nxt = {bcd_adj[BW-2:0], bin_work[BIN_W-1]};
  assign ovf_nxt = ovf_acc | bcd_adj[BW-1];

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bin_work  <= '0;
      bcd_work  <= '0;
      ovf_acc   <= 1'b0;
      neg_work  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd       <= '0;
      bcd_neg   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            bin_work <= mag;
            neg_work <= neg_in;
            bcd_work <= '0;
            ovf_acc  <= 1'b0;
            cnt      <= CW'(BIN_W);
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_work <= bcd_nxt;
          bin_work <= {bin_work[BIN_W-2:0], 1'b0};
          ovf_acc  <= ovf_nxt;
          cnt      <= cnt - 1'b1;
          // Last bit: publish the result straight from the next-state values.
          if (cnt == CW'(1)) begin
            bcd       <= ovf_nxt ? {DIGITS{BCD_NINE}} : bcd_nxt;
            overflow  <= ovf_nxt;
            bcd_neg   <= neg_work;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three instances (8b/3d, 8b/2d, 16b/5d),
// expected results from a decimal arithmetic model, checked by a monitor.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic iv[3], ir[3], ov[3], ordy[3], neg[3], ovf[3];
  logic [7:0]  b0, b1;
  logic [15:0] b2;
  logic [11:0] bcd0;
  logic [7:0]  bcd1;
  logic [19:0] bcd2;
  logic [19:0] bcd[3];
  assign bcd[0] = {8'd0, bcd0};
  assign bcd[1] = {12'd0, bcd1};
  assign bcd[2] = bcd2;

  int bw[3] = '{8, 8, 16};
  int dg[3] = '{3, 2, 5};

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .bin(b0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .bcd(bcd0), .bcd_neg(neg[0]), .overflow(ovf[0]));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .bin(b1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .bcd(bcd1), .bcd_neg(neg[1]), .overflow(ovf[1]));
  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .bin(b2),
    .out_valid(ov[2]), .out_ready(ordy[2]), .bcd(bcd2), .bcd_neg(neg[2]), .overflow(ovf[2]));

  typedef struct {
    int          id;
    int          acc;
    logic [21:0] exp;   // {overflow, neg, bcd[19:0]}
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  // Reference: decimal digits by division; saturate when value >= 10^digits.
  function automatic logic [21:0] model(input int i, input longint v);
    longint      m = v;
    longint      lim = 1;
    logic        n = 1'b0;
    logic        o = 1'b0;
    logic [19:0] r = '0;
`ifdef BIN2BCD_SIGNED_EN
    if (v >= (64'd1 << (bw[i] - 1))) begin
      n = 1'b1;
      m = (64'd1 << bw[i]) - v;
    end
`endif
    for (int k = 0; k < dg[i]; k++) lim = lim * 10;
    if (m >= lim) begin
      o = 1'b1;
      for (int k = 0; k < dg[i]; k++) r[4*k +: 4] = 4'h9;
    end else begin
      for (int k = 0; k < dg[i]; k++) begin
        r[4*k +: 4] = 4'(m % 10);
        m = m / 10;
      end
    end
    return {o, n, r};
  endfunction

  task automatic set_bin(input int i, input logic [15:0] v);
    case (i)
      0: b0 = v[7:0];
      1: b1 = v[7:0];
      default: b2 = v;
    endcase
  endtask

  // Present one operand, wait for acceptance, push the expected response.
  task automatic send(input int i, input logic [15:0] v, output int acc);
    int   n = 0;
    exp_t e;
    acc = -1;
    @(posedge clk); #1;
    set_bin(i, v);
    iv[i] = 1'b1;
    forever begin
      @(negedge clk);
      if (ir[i]) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 0, 1);
        iv[i] = 1'b0;
        return;
      end
    end
    e.id  = i;
    e.acc = cyc + 1;
    e.exp = model(i, (i == 2) ? longint'(v) : longint'(v[7:0]));
    acc   = e.acc;
    q.push_back(e);
    @(posedge clk); #1;
    iv[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        chk("drain_timeout", q.size(), 0);
        q.delete();
      end
    end
    @(negedge clk);
  endtask

  logic pv[3]      = '{1'b0, 1'b0, 1'b0};
  logic hs_prev[3] = '{1'b0, 1'b0, 1'b0};

  task automatic mon(input int i);
    if (hs_prev[i]) chk("valid_drop_after_hs", ov[i], 0);
    hs_prev[i] = 1'b0;
    if (ov[i]) begin
      if (q.size() == 0 || q[0].id != i) begin
        chk("unexpected_out_valid", i, -1);
      end else begin
        if (!pv[i]) chk("latency", cyc - q[0].acc, bw[i]);
        chk("bcd", bcd[i], q[0].exp[19:0]);
        chk("overflow", ovf[i], q[0].exp[21]);
        chk("bcd_neg", neg[i], q[0].exp[20]);
        chk("in_ready_in_done", ir[i], 0);
        if (ordy[i]) begin
          void'(q.pop_front());
          hs_prev[i] = 1'b1;
        end
      end
    end
    pv[i] = ov[i];
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) for (int i = 0; i < 3; i++) mon(i);
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int a, a2;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
    end
    b0 = '0; b1 = '0; b2 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", ir[i], 1);
      chk("rst_out_valid", ov[i], 0);
      chk("rst_bcd", bcd[i], 0);
      chk("rst_overflow", ovf[i], 0);
      chk("rst_bcd_neg", neg[i], 0);
    end

    // Leave a nonzero result held, then reset in the middle of the next conversion.
    send(0, 16'd200, a);
    wait_idle();
    send(0, 16'd77, a);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", ir[0], 1);
    chk("midrst_out_valid", ov[0], 0);
    chk("midrst_bcd", bcd[0], 0);
    chk("midrst_overflow", ovf[0], 0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("postrst_in_ready", ir[0], 1);

    // Directed corner values, then random traffic on the 8b/3d instance.
    send(0, 16'd0, a);   wait_idle();
    send(0, 16'd9, a);   wait_idle();
    send(0, 16'd255, a); wait_idle();
    send(0, 16'd128, a); wait_idle();
    for (int n = 0; n < 20; n++) send(0, 16'($urandom_range(0, 255)), a);
    wait_idle();

    // Downstream stall: result must hold, new input must be ignored.
    ordy[0] = 1'b0;
    send(0, 16'd173, a);
    for (int n = 0; n < 40 && !ov[0]; n++) @(negedge clk);
    chk("stall_valid_seen", ov[0], 1);
    @(posedge clk); #1;
    set_bin(0, 16'd55);
    iv[0] = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    wait_idle();
    repeat (12) @(negedge clk);

    // Two-digit instance: overflow saturation and the largest fitting value.
    send(1, 16'd150, a); wait_idle();
    send(1, 16'd99, a);  wait_idle();
    for (int n = 0; n < 12; n++) send(1, 16'($urandom_range(0, 255)), a);
    wait_idle();

    // Wide instance: full-scale value and back-to-back spacing.
    send(2, 16'd65535, a);
    send(2, 16'($urandom_range(0, 65535)), a2);
    chk("b2b_spacing", a2 - a, 18);
    wait_idle();
    for (int n = 0; n < 6; n++) send(2, 16'($urandom_range(0, 65535)), a);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
